fpmac_seq: RTL and testbench

FPMAC_SEQ -- requirements
Module: fpmac_seq

---
 rtl/fpmac_pkg.sv | 19 +
 rtl/fpmac_seq.sv | 100 ++++++++++
 tb/tb_fpmac_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fpmac_pkg.sv
// Shared constants and FSM encoding for the FP8 MAC job sequencer.
package fpmac_pkg;
  localparam int FP8_W   = 8;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  // Jobs longer than the MAC can take are trimmed to MAX_LEN pairs.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    return (int'(len) > MAX_LEN) ? CNT_W'(MAX_LEN) : len;
  endfunction
endpackage

// File: rtl/fpmac_seq.sv
// Sequences one MAC job: clear, stream cmd_len operand pairs, capture the sum; result 2 cycles after last pair.
// Operands stall on op_valid; the result holds until res_ready; abort drops the job from any busy state.
module fpmac_seq
  import fpmac_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [FP8_W-1:0] op_a,
  input  logic [FP8_W-1:0] op_b,
  output logic [FP8_W-1:0] mac_a,
  output logic [FP8_W-1:0] mac_b,
  output logic             mac_start,
  output logic             mac_clr,
  input  logic [FP8_W-1:0] mac_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FP8_W-1:0] res_data,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [FP8_W-1:0]   res_data_q, res_data_d;

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    remaining_q <= remaining_d;
    res_data_q  <= res_data_d;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    res_data_d  = res_data_q;
    cmd_ready   = 1'b0;
    op_ready    = 1'b0;
    mac_start   = 1'b0;
    mac_clr     = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    res_valid   = 1'b0;

    if (reset) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      res_data_d  = '0;
      mac_clr     = 1'b1;
      cmd_ready   = 1'b1;
    end else if (abort && state_q != ST_IDLE) begin
      // Abort wins over every handshake, so nothing is accepted this cycle.
      state_d     = ST_IDLE;
      remaining_d = '0;
      mac_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            remaining_d = clamp_len(cmd_len);
            state_d     = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          mac_clr = 1'b1;
          state_d = (remaining_q != '0) ? ST_RUN : ST_DRAIN;
        end
        ST_RUN: begin
          op_ready = 1'b1;
          if (op_valid) begin
            mac_a       = op_a;
            mac_b       = op_b;
            mac_start   = 1'b1;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // MAC has absorbed the last pair by now; its sum is final.
          res_data_d = mac_sum;
          state_d    = ST_RESULT;
        end
        ST_RESULT: begin
          res_valid = 1'b1;
          if (res_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign res_data = res_data_q;
  assign busy     = !reset && (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpmac_seq.sv
// Bench for fpmac_seq: stand-in MAC in the parent, reference sums from plain integer arithmetic.
module tb_fpmac_seq;
  logic       clk = 1'b0;
  logic       reset, abort, cmd_valid, op_valid, res_ready;
  logic [4:0] cmd_len;
  logic [7:0] op_a, op_b, mac_sum;
  logic       cmd_ready, op_ready, mac_start, mac_clr, res_valid, busy;
  logic [7:0] mac_a, mac_b, res_data;
  logic [7:0] mac_acc;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  fpmac_seq dut (
    .clk(clk), .reset(reset), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start), .mac_clr(mac_clr),
    .mac_sum(mac_sum), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  // Stand-in MAC: modulo-256 accumulation of byte products.
  always_ff @(posedge clk) begin
    if (mac_clr)        mac_acc <= '0;
    else if (mac_start) mac_acc <= mac_acc + 8'(mac_a * mac_b);
  end
  assign mac_sum = mac_acc;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(); reset = 1'b1; #1;
    n_tests++; if ({cmd_ready, busy, op_ready, mac_start, mac_clr, res_valid} !== 6'b100010) begin n_fail++; $display("FAIL reset_outputs: got %b want 100010", {cmd_ready, busy, op_ready, mac_start, mac_clr, res_valid}); end
    n_tests++; if ({mac_a, mac_b} !== 16'h0000) begin n_fail++; $display("FAIL reset_mac_ops: got %h want 0000", {mac_a, mac_b}); end
    tick(); reset = 1'b0; #1;
    n_tests++; if ({cmd_ready, busy, op_ready, mac_start, mac_clr, res_valid} !== 6'b100000) begin n_fail++; $display("FAIL idle_outputs: got %b want 100000", {cmd_ready, busy, op_ready, mac_start, mac_clr, res_valid}); end
    n_tests++; if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data: got %h want 00", res_data); end
  endtask

  task automatic test_len3();
    int ref_acc = 0;
    logic [7:0] a, b;
    tick(); cmd_len = 5'd3; cmd_valid = 1'b1; #1;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL len3_cmd_ready: got %b want 1", cmd_ready); end
    tick(); cmd_valid = 1'b0; op_valid = 1'b1; op_a = 8'hA5; op_b = 8'h5A; #1;
    n_tests++; if ({busy, op_ready, mac_start, mac_clr, mac_a} !== {4'b1001, 8'h00}) begin n_fail++; $display("FAIL len3_clear: got %b want 1001_00000000", {busy, op_ready, mac_start, mac_clr, mac_a}); end
    for (int i = 0; i < 3; i++) begin
      tick(); a = 8'($urandom); b = 8'($urandom); op_a = a; op_b = b; #1;
      n_tests++; if ({op_ready, mac_start, mac_a, mac_b} !== {2'b11, a, b}) begin n_fail++; $display("FAIL len3_pair%0d: got %h want %h", i, {op_ready, mac_start, mac_a, mac_b}, {2'b11, a, b}); end
      ref_acc += int'(a) * int'(b);
    end
    tick(); op_a = 8'h77; #1;
    n_tests++; if ({op_ready, mac_start, res_valid, mac_a} !== 11'h000) begin n_fail++; $display("FAIL len3_drain: got %h want 000", {op_ready, mac_start, res_valid, mac_a}); end
    tick(); op_valid = 1'b0; #1;
    n_tests++; if ({res_valid, res_data} !== {1'b1, 8'(ref_acc % 256)}) begin n_fail++; $display("FAIL len3_result: got %h want %h", {res_valid, res_data}, {1'b1, 8'(ref_acc % 256)}); end
    res_ready = 1'b1;
    tick(); res_ready = 1'b0; #1;
    n_tests++; if ({cmd_ready, busy, res_valid, res_data} !== {3'b100, 8'(ref_acc % 256)}) begin n_fail++; $display("FAIL len3_idle_hold: got %h want %h", {cmd_ready, busy, res_valid, res_data}, {3'b100, 8'(ref_acc % 256)}); end
  endtask

  task automatic test_gaps();
    logic [6:0] pat = 7'b1110101;
    int ref_acc = 0;
    int taken = 0;
    logic hs;
    logic [7:0] a, b;
    tick(); cmd_len = 5'd4; cmd_valid = 1'b1; #1;
    tick(); cmd_valid = 1'b0; #1;
    n_tests++; if (mac_clr !== 1'b1) begin n_fail++; $display("FAIL gaps_clear: got %b want 1", mac_clr); end
    for (int i = 0; i < 7; i++) begin
      tick(); a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255));
      op_valid = pat[i]; op_a = a; op_b = b; #1;
      hs = pat[i] && (taken < 4);
      n_tests++; if ({op_ready, mac_start} !== {taken < 4, hs}) begin n_fail++; $display("FAIL gaps_ctl%0d: got %b want %b", i, {op_ready, mac_start}, {taken < 4, hs}); end
      n_tests++; if (mac_a !== (hs ? a : 8'h00)) begin n_fail++; $display("FAIL gaps_mac_a%0d: got %h want %h", i, mac_a, hs ? a : 8'h00); end
      if (hs) begin ref_acc += int'(a) * int'(b); taken++; end
    end
    tick(); op_valid = 1'b0; #1;
    n_tests++; if ({res_valid, res_data} !== {1'b1, 8'(ref_acc % 256)}) begin n_fail++; $display("FAIL gaps_result: got %h want %h", {res_valid, res_data}, {1'b1, 8'(ref_acc % 256)}); end
    res_ready = 1'b1;
    tick(); res_ready = 1'b0;
  endtask

  task automatic test_len0();
    tick(); cmd_len = 5'd0; cmd_valid = 1'b1; #1;
    tick(); cmd_valid = 1'b0; #1;
    n_tests++; if ({mac_clr, res_valid, op_ready} !== 3'b100) begin n_fail++; $display("FAIL len0_clear: got %b want 100", {mac_clr, res_valid, op_ready}); end
    tick(); #1;
    n_tests++; if ({mac_clr, res_valid, op_ready, busy} !== 4'b0001) begin n_fail++; $display("FAIL len0_drain: got %b want 0001", {mac_clr, res_valid, op_ready, busy}); end
    tick(); #1;
    n_tests++; if ({res_valid, res_data} !== 9'h100) begin n_fail++; $display("FAIL len0_result: got %h want 100", {res_valid, res_data}); end
    res_ready = 1'b1;
    tick(); res_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [7:0] a = 8'($urandom_range(1, 255));
    logic [7:0] b = 8'($urandom_range(1, 255));
    logic [7:0] want = 8'((int'(a) * int'(b)) % 256);
    tick(); cmd_len = 5'd1; cmd_valid = 1'b1; #1;
    tick(); cmd_valid = 1'b0; #1;
    tick(); op_valid = 1'b1; op_a = a; op_b = b; #1;
    tick(); op_valid = 1'b0; #1;
    for (int i = 0; i < 6; i++) begin
      tick(); res_ready = (i == 5); #1;
      n_tests++; if ({res_valid, cmd_ready, res_data} !== {2'b10, want}) begin n_fail++; $display("FAIL hold_cyc%0d: got %h want %h", i, {res_valid, cmd_ready, res_data}, {2'b10, want}); end
    end
    tick(); res_ready = 1'b0; #1;
    n_tests++; if ({res_valid, cmd_ready, busy, res_data} !== {3'b010, want}) begin n_fail++; $display("FAIL hold_release: got %h want %h", {res_valid, cmd_ready, busy, res_data}, {3'b010, want}); end
  endtask

  task automatic test_abort();
    tick(); cmd_len = 5'd5; cmd_valid = 1'b1; #1;
    tick(); cmd_valid = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      tick(); op_valid = 1'b1; op_a = 8'($urandom_range(1, 255)); op_b = 8'($urandom_range(1, 255)); #1;
      n_tests++; if (mac_start !== 1'b1) begin n_fail++; $display("FAIL abort_pair%0d: got %b want 1", i, mac_start); end
    end
    tick(); abort = 1'b1; #1;
    n_tests++; if ({mac_clr, mac_start, op_ready, res_valid} !== 4'b1000) begin n_fail++; $display("FAIL abort_cycle: got %b want 1000", {mac_clr, mac_start, op_ready, res_valid}); end
    tick(); abort = 1'b0; op_valid = 1'b0; #1;
    n_tests++; if ({busy, cmd_ready, mac_clr} !== 3'b010) begin n_fail++; $display("FAIL abort_idle: got %b want 010", {busy, cmd_ready, mac_clr}); end
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_result%0d: got %b want 0", i, res_valid); end
    end
    tick(); abort = 1'b1; cmd_len = 5'd1; cmd_valid = 1'b1; #1;
    n_tests++; if ({cmd_ready, mac_clr} !== 2'b10) begin n_fail++; $display("FAIL abort_in_idle: got %b want 10", {cmd_ready, mac_clr}); end
    tick(); abort = 1'b0; cmd_valid = 1'b0; #1;
    n_tests++; if ({busy, mac_clr} !== 2'b11) begin n_fail++; $display("FAIL abort_next_clear: got %b want 11", {busy, mac_clr}); end
    tick(); op_valid = 1'b1; op_a = 8'h00; op_b = 8'h35; #1;
    n_tests++; if ({mac_start, mac_a, mac_b} !== {1'b1, 16'h0035}) begin n_fail++; $display("FAIL zero_pair: got %h want 10035", {mac_start, mac_a, mac_b}); end
    tick(); op_valid = 1'b0; #1;
    tick(); #1;
    n_tests++; if ({res_valid, res_data} !== 9'h100) begin n_fail++; $display("FAIL zero_pair_result: got %h want 100", {res_valid, res_data}); end
    res_ready = 1'b1;
    tick(); res_ready = 1'b0;
  endtask

  task automatic test_reset_in_result();
    tick(); cmd_len = 5'd2; cmd_valid = 1'b1; #1;
    tick(); cmd_valid = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      tick(); op_valid = 1'b1; op_a = 8'($urandom_range(1, 11)); op_b = 8'($urandom_range(1, 11)); #1;
    end
    tick(); op_valid = 1'b0; #1;
    tick(); #1;
    n_tests++; if (res_valid !== 1'b1 || res_data === 8'h00) begin n_fail++; $display("FAIL rst_result_setup: got valid %b data %h want valid 1 data nonzero", res_valid, res_data); end
    tick(); reset = 1'b1; #1;
    n_tests++; if ({res_valid, mac_clr} !== 2'b01) begin n_fail++; $display("FAIL rst_result_cycle: got %b want 01", {res_valid, mac_clr}); end
    tick(); reset = 1'b0; #1;
    n_tests++; if ({res_valid, cmd_ready, busy, res_data} !== {3'b010, 8'h00}) begin n_fail++; $display("FAIL rst_result_after: got %h want %h", {res_valid, cmd_ready, busy, res_data}, {3'b010, 8'h00}); end
  endtask

  // Random jobs, lengths 0..31 (clamped to 16), random operand gaps and result stalls.
  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      int len = $urandom_range(0, 31);
      int n = (len > 16) ? 16 : len;
      int got = 0;
      int guard = 0;
      int ref_acc = 0;
      int stall = $urandom_range(0, 3);
      logic v;
      logic [7:0] a, b;
      tick(); cmd_len = 5'(len); cmd_valid = 1'b1; #1;
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_cmd_ready: got %b want 1", j, cmd_ready); end
      tick(); cmd_valid = 1'b0; #1;
      n_tests++; if (mac_clr !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_clear: got %b want 1", j, mac_clr); end
      while (got < n && guard < 200) begin
        tick(); v = 1'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom);
        op_valid = v; op_a = a; op_b = b; #1;
        n_tests++; if ({op_ready, mac_start, mac_a} !== {1'b1, v, v ? a : 8'h00}) begin n_fail++; $display("FAIL rnd%0d_op: got %h want %h", j, {op_ready, mac_start, mac_a}, {1'b1, v, v ? a : 8'h00}); end
        if (v) begin ref_acc += int'(a) * int'(b); got++; end
        guard++;
      end
      n_tests++; if (got != n) begin n_fail++; $display("FAIL rnd%0d_accept_count: got %0d want %0d", j, got, n); end
      tick(); op_valid = 1'($urandom_range(0, 1)); #1;
      n_tests++; if ({op_ready, mac_start, res_valid} !== 3'b000) begin n_fail++; $display("FAIL rnd%0d_drain: got %b want 000", j, {op_ready, mac_start, res_valid}); end
      tick(); op_valid = 1'b0; #1;
      n_tests++; if ({res_valid, res_data} !== {1'b1, 8'(ref_acc % 256)}) begin n_fail++; $display("FAIL rnd%0d_result: got %h want %h", j, {res_valid, res_data}, {1'b1, 8'(ref_acc % 256)}); end
      for (int s = 0; s < stall; s++) tick();
      #1;
      n_tests++; if ({res_valid, res_data} !== {1'b1, 8'(ref_acc % 256)}) begin n_fail++; $display("FAIL rnd%0d_stall: got %h want %h", j, {res_valid, res_data}, {1'b1, 8'(ref_acc % 256)}); end
      res_ready = 1'b1;
      tick(); res_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    test_reset();
    test_len3();
    test_gaps();
    test_len0();
    test_hold();
    test_abort();
    test_reset_in_result();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, limit 400000 ns reached");
    $fatal(1);
  end
endmodule
